// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter operation encoding for the
// binary/Gray counter family and its downstream consumers.
package gray_pkg;

   localparam int unsigned GRAY_MAX_WIDTH = 32;

   // Operation selected for the current cycle; reset is handled in the
   // register process and therefore has no encoding here.
   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_UP   = 2'd2,
      OP_DOWN = 2'd3
   } cnt_op_e;

   function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
      input logic [GRAY_MAX_WIDTH-1:0] b
   );
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; zero-extended narrow codes decode correctly.
   function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
      input logic [GRAY_MAX_WIDTH-1:0] g
   );
      logic [GRAY_MAX_WIDTH-1:0] b;
      b = '0;
      b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
      for (int unsigned i = GRAY_MAX_WIDTH - 1; i > 0; i--) begin
         b[i-1] = b[i] ^ g[i-1];
      end
      return b;
   endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Purely combinational WIDTH-bit binary to reflected-binary Gray encoder
// built on the shared package function.
module bin2gray_enc
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);

   logic [GRAY_MAX_WIDTH-1:0] bin_wide;
   logic [GRAY_MAX_WIDTH-1:0] gray_wide;

   // Zero-extension keeps the top Gray bit equal to the top binary bit.
   always_comb begin
      bin_wide = '0;
      bin_wide[WIDTH-1:0] = bin_i;
   end

   assign gray_wide = bin2gray(bin_wide);
   assign gray_o    = gray_wide[WIDTH-1:0];

   generate
      if (WIDTH < GRAY_MAX_WIDTH) begin : g_unused_hi
         logic unused_hi;
         assign unused_hi = ^gray_wide[GRAY_MAX_WIDTH-1:WIDTH];
      end
   endgenerate

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with load; binary and Gray views are both
// registered so gray_o changes one bit per counting step.
module gray_counter
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] bin_o,
   output logic [WIDTH-1:0] gray_o,
   output logic             wrap_o
);

   cnt_op_e          op;
   logic [WIDTH-1:0] cnt_d,  cnt_q;
   logic [WIDTH-1:0] gray_d, gray_q;
   logic             wrap_d, wrap_q;

   always_comb begin
      op = OP_HOLD;
      if (load) begin
         op = OP_LOAD;
      end else if (en) begin
         op = up ? OP_UP : OP_DOWN;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      unique case (op)
         OP_LOAD: cnt_d = load_bin;
         OP_UP: begin
            cnt_d  = cnt_q + 1'b1;
            wrap_d = &cnt_q;
         end
         OP_DOWN: begin
            cnt_d  = cnt_q - 1'b1;
            wrap_d = ~|cnt_q;
         end
         default: cnt_d = cnt_q;
      endcase
   end

   // Encoding the next binary value keeps gray_q registered, not derived from cnt_q.
   bin2gray_enc #(
      .WIDTH (WIDTH)
   ) u_enc (
      .bin_i  (cnt_d),
      .gray_o (gray_d)
   );

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bin_o  = cnt_q;
   assign gray_o = gray_q;
   assign wrap_o = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter at WIDTH 4 (vector table), 32 (load
// corner) and 8 (random stimulus against a modular reference model).
module tb_gray_counter;
   import gray_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // WIDTH=4 instance
   logic       n4, en4, up4, ld4;
   logic [3:0] lb4, bin4, gray4;
   logic       wrap4;
   gray_counter #(.WIDTH(4)) u4 (
      .clk(clk), .nrst(n4), .en(en4), .up(up4), .load(ld4), .load_bin(lb4),
      .bin_o(bin4), .gray_o(gray4), .wrap_o(wrap4)
   );

   // WIDTH=32 instance
   logic        n32, en32, up32, ld32;
   logic [31:0] lb32, bin32, gray32;
   logic        wrap32;
   gray_counter #(.WIDTH(32)) u32 (
      .clk(clk), .nrst(n32), .en(en32), .up(up32), .load(ld32), .load_bin(lb32),
      .bin_o(bin32), .gray_o(gray32), .wrap_o(wrap32)
   );

   // WIDTH=8 instance
   logic       n8, en8, up8, ld8;
   logic [7:0] lb8, bin8, gray8;
   logic       wrap8;
   gray_counter #(.WIDTH(8)) u8 (
      .clk(clk), .nrst(n8), .en(en8), .up(up8), .load(ld8), .load_bin(lb8),
      .bin_o(bin8), .gray_o(gray8), .wrap_o(wrap8)
   );

   typedef struct {
      string      name;
      logic       nrst, en, up, load;
      logic [3:0] lb;
      logic [3:0] eb, eg;
      logic       ew;
   } vec_t;

   vec_t vecs[$];
   logic [3:0] gseq [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic nrst, input logic en, input logic up,
                      input logic load, input logic [3:0] lb, input logic [3:0] eb,
                      input logic [3:0] eg, input logic ew);
      vec_t v;
      v.name = name; v.nrst = nrst; v.en = en; v.up = up; v.load = load;
      v.lb = lb; v.eb = eb; v.eg = eg; v.ew = ew;
      vecs.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  prev_g4;
      logic        prev_valid;
      logic [7:0]  m_cnt, m_next, m_prev_gray;
      logic        m_wrap, step;

      gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

      n4 = 1'b0; en4 = 1'b0; up4 = 1'b0; ld4 = 1'b0; lb4 = '0;
      n32 = 1'b0; en32 = 1'b0; up32 = 1'b0; ld32 = 1'b0; lb32 = '0;
      n8 = 1'b0; en8 = 1'b0; up8 = 1'b0; ld8 = 1'b0; lb8 = '0;

      // ---------------- WIDTH=4 vector table ----------------
      add("w4_reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
      for (int i = 0; i < 4; i++)
         add("w4_idle", 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
      for (int i = 1; i <= 17; i++)
         add("w4_up", 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'(i % 16), gseq[i % 16], i == 16);
      add("w4_load0",   1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0);
      add("w4_down",    1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'h8, 1'b1);
      add("w4_hold",    1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'h8, 1'b0);
      add("w4_down2",   1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hE, 4'h9, 1'b0);
      add("w4_ldF_en",  1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'h8, 1'b0);
      add("w4_up_wrap", 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
      add("w4_up1",     1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 1'b0);
      add("w4_rst_mid", 1'b0, 1'b1, 1'b1, 1'b1, 4'h7, 4'h0, 4'h0, 1'b0);
      add("w4_resume",  1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 4'h1, 1'b0);
      add("w4_dir_dn",  1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
      add("w4_dir_dn2", 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'hF, 4'h8, 1'b1);
      add("w4_dir_up",  1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1);

      prev_g4 = '0;
      prev_valid = 1'b0;
      foreach (vecs[i]) begin
         n4 = vecs[i].nrst; en4 = vecs[i].en; up4 = vecs[i].up;
         ld4 = vecs[i].load; lb4 = vecs[i].lb;
         @(posedge clk); #1;
         check({vecs[i].name, "_bin"},  32'(bin4),  32'(vecs[i].eb));
         check({vecs[i].name, "_gray"}, 32'(gray4), 32'(vecs[i].eg));
         check({vecs[i].name, "_wrap"}, 32'(wrap4), 32'(vecs[i].ew));
         if (prev_valid && vecs[i].nrst && vecs[i].en && !vecs[i].load)
            check({vecs[i].name, "_hamming"}, 32'($countones(gray4 ^ prev_g4)), 32'd1);
         prev_g4 = vecs[i].eg;
         prev_valid = 1'b1;
      end
      n4 = 1'b1; en4 = 1'b0; ld4 = 1'b0;

      // ---------------- WIDTH=32 load corner ----------------
      n32 = 1'b0;
      @(posedge clk); #1;
      check("w32_reset_bin", bin32, 32'h0);
      n32 = 1'b1; ld32 = 1'b1; en32 = 1'b1; up32 = 1'b1; lb32 = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check("w32_load_bin",  bin32,        32'hFFFF_FFFF);
      check("w32_load_gray", gray32,       32'h8000_0000);
      check("w32_load_wrap", 32'(wrap32),  32'd0);
      ld32 = 1'b0;
      @(posedge clk); #1;
      check("w32_wrap_bin",  bin32,        32'h0);
      check("w32_wrap_gray", gray32,       32'h0);
      check("w32_wrap_wrap", 32'(wrap32),  32'd1);
      en32 = 1'b0;
      @(posedge clk); #1;
      check("w32_after_wrap", 32'(wrap32), 32'd0);

      // ---------------- WIDTH=8 random against model ----------------
      m_cnt = '0;
      m_prev_gray = '0;
      for (int c = 0; c < 10000; c++) begin
         n8  = (c == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
         ld8 = ($urandom_range(0, 7) == 0);
         en8 = ($urandom_range(0, 3) != 0);
         up8 = $urandom_range(0, 1);
         lb8 = 8'($urandom_range(0, 255));
         // Bias toward the wrap values so both wrap directions get exercised.
         if ($urandom_range(0, 15) == 0) lb8 = $urandom_range(0, 1) ? 8'hFF : 8'h00;

         step = 1'b0;
         if (!n8) begin
            m_next = '0; m_wrap = 1'b0;
         end else if (ld8) begin
            m_next = lb8; m_wrap = 1'b0;
         end else if (en8) begin
            step = 1'b1;
            if (up8) begin
               m_wrap = (m_cnt == 8'hFF); m_next = m_cnt + 8'd1;
            end else begin
               m_wrap = (m_cnt == 8'h00); m_next = m_cnt - 8'd1;
            end
         end else begin
            m_next = m_cnt; m_wrap = 1'b0;
         end

         @(posedge clk); #1;
         m_cnt = m_next;
         check("w8_bin",  32'(bin8),  32'(m_cnt));
         check("w8_wrap", 32'(wrap8), 32'(m_wrap));
         check("w8_gray2bin", gray2bin({24'h0, gray8}), 32'(m_cnt));
         if (step)
            check("w8_hamming", 32'($countones(gray8 ^ m_prev_gray)), 32'd1);
         if (!n8)
            check("w8_reset_all", {bin8, gray8, 15'h0, wrap8}, 32'h0);
         m_prev_gray = m_cnt ^ (m_cnt >> 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
